alarm_sequencer: RTL and testbench
==================================

// Module: alarm_sequencer
// PURPOSE
//  Alarm controller for the VGA digital clock; replaces the raw match-driven buzzer toggle in top.
//  Compares running time against alarm registers from new_binary_clock and sequences ARMED/RINGING/SNOOZE.
//  Generates a gated, cadenced buzzer tone and status flags for pixel_clk_gen overlays.
//  Single clock domain (clk_100MHz).
// PARAMETERS
//  CLK_HZ      100_000_000  input clock frequency
//  TONE_HZ     2000         buzzer square-wave frequency; TONE_DIV = CLK_HZ/(2*TONE_HZ) cycles per half-period
//  SNOOZE_SEC  300          snooze length, counted in tick_1Hz pulses
//  RING_SEC    60           auto-dismiss timeout while RINGING, in tick_1Hz pulses
//  MAX_SNOOZE  3            snoozes allowed per alarm event (1..3)
// PORTS
//  clk_100MHz   in   1  system clock
//  reset        in   1  asynchronous, active-high reset
//  tick_1Hz     in   1  one-cycle pulse per second from new_binary_clock
//  hr_10s/hr_1s/min_10s/min_1s/sec_10s/sec_1s  in 4 each  running time, BCD
//  alarm_hr_10s/alarm_hr_1s/alarm_min_10s/alarm_min_1s  in 4 each  alarm time, BCD
//  alarm_en     in   1  level; sw[0]
//  set_alarm    in   1  level; alarm being edited, suppresses triggering
//  snooze       in   1  one-cycle pulse (debounced upstream)
//  dismiss      in   1  one-cycle pulse (debounced upstream)
//  buzzer       out  1  tone output to buzzer pin
//  ringing      out  1  state == RINGING
//  snoozing     out  1  state == SNOOZE
//  snooze_cnt   out  2  snoozes used in current alarm event
// BEHAVIOUR
//  Reset: state=IDLE; buzzer, ringing, snoozing, snooze_cnt, all counters, match_prev = 0.
//  match_now = all four hr/min digit pairs equal AND sec_10s==0 AND sec_1s==0 (combinational).
//  match_prev is match_now registered; trigger = match_now & ~match_prev & ~set_alarm.
//  States (all outputs are registered decodes of state):
//   IDLE:    alarm_en=1 -> ARMED.
//   ARMED:   trigger -> RINGING; snooze_cnt<=0; ring timer<=0; tone/cadence counters<=0.
//   RINGING: dismiss -> ARMED. snooze & snooze_cnt<MAX_SNOOZE -> SNOOZE, snooze_cnt+1, snooze timer<=0.
//            snooze & snooze_cnt==MAX_SNOOZE -> ARMED (acts as dismiss).
//            tick_1Hz while ring timer==RING_SEC-1 -> ARMED (timeout); otherwise tick_1Hz increments ring timer.
//   SNOOZE:  dismiss -> ARMED. tick_1Hz while snooze timer==SNOOZE_SEC-1 -> RINGING,
//            ring timer and tone/cadence counters cleared; else tick_1Hz increments. snooze ignored.
//  Any state: alarm_en=0 -> IDLE next edge, highest priority; snooze_cnt cleared.
//  Priority within a cycle: alarm_en=0 > dismiss > snooze > timer expiry > trigger.
//  Trigger registers one cycle after match_now rises; ringing goes high on that edge.
//  Tone: counter wraps at TONE_DIV-1 and toggles tone_q; runs only in RINGING.
//  Cadence: counter of CLK_HZ/2 cycles toggles beep_on; beep_on=1 on RINGING entry.
//  buzzer (registered) = RINGING & beep_on & tone_q; 0 the cycle after leaving RINGING.
//  Dismissed within second :00: match_now stays high with no new edge, so no retrigger. Next trigger is 24 h later.
//  set_alarm high during the :00 edge suppresses that event entirely, with no late trigger.
//  Counters sized with $clog2 of their terminal value. No overflow: all wrap at terminal count.
//  Reset asserted mid-RINGING: buzzer low immediately (async), state IDLE.
// TESTING  (scaled: CLK_HZ=1000, TONE_HZ=100 -> TONE_DIV=5, SNOOZE_SEC=3, RING_SEC=4, MAX_SNOOZE=2)
//  alarm 07:30, en=1, time 07:29:59->07:30:00 -> ringing=1 one clk after match edge; buzzer toggles every 5 clks during beep_on.
//  Ringing, no input, 4 tick_1Hz pulses -> state ARMED on 4th tick, buzzer=0 next clk, no retrigger during 07:30:xx.
//  Ringing, snooze pulse -> snoozing=1, snooze_cnt=1; 3 ticks later ringing=1. 2nd snooze -> cnt=2. 3rd snooze -> ARMED.
//  snooze and dismiss in the same cycle -> ARMED, snooze_cnt unchanged, snoozing=0.
//  set_alarm=1 across 07:30:00 -> no ringing. alarm_en=0 mid-SNOOZE -> IDLE, snooze_cnt=0.
//  reset pulse while buzzer=1 -> buzzer=0 asynchronously; all outputs 0 and state IDLE after release.

Source files
------------

// File: rtl/alarm_sequencer.sv
// Alarm controller for the VGA digital clock.
// Watches the running BCD time against the alarm registers and steps through
// IDLE / ARMED / RINGING / SNOOZE. While ringing it produces a cadenced
// square-wave tone for the buzzer pin and exposes status flags to the overlays.
module alarm_sequencer #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TONE_HZ    = 2000,
  parameter int SNOOZE_SEC = 300,
  parameter int RING_SEC   = 60,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       tick_1Hz,
  input  logic [3:0] hr_10s,
  input  logic [3:0] hr_1s,
  input  logic [3:0] min_10s,
  input  logic [3:0] min_1s,
  input  logic [3:0] sec_10s,
  input  logic [3:0] sec_1s,
  input  logic [3:0] alarm_hr_10s,
  input  logic [3:0] alarm_hr_1s,
  input  logic [3:0] alarm_min_10s,
  input  logic [3:0] alarm_min_1s,
  input  logic       alarm_en,
  input  logic       set_alarm,
  input  logic       snooze,
  input  logic       dismiss,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozing,
  output logic [1:0] snooze_cnt
);

  localparam int TONE_DIV = CLK_HZ / (2 * TONE_HZ);
  localparam int CAD_DIV  = CLK_HZ / 2;

  localparam int TW = (TONE_DIV   > 1) ? $clog2(TONE_DIV)   : 1;
  localparam int CW = (CAD_DIV    > 1) ? $clog2(CAD_DIV)    : 1;
  localparam int RW = (RING_SEC   > 1) ? $clog2(RING_SEC)   : 1;
  localparam int SW = (SNOOZE_SEC > 1) ? $clog2(SNOOZE_SEC) : 1;

  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);
  localparam logic [CW-1:0] CAD_LAST  = CW'(CAD_DIV - 1);
  localparam logic [RW-1:0] RING_LAST = RW'(RING_SEC - 1);
  localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_SEC - 1);
  localparam logic [1:0]    SNZ_MAX   = 2'(MAX_SNOOZE);

  typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} state_t;

  state_t        state, state_nx;
  logic          match_now, match_prev, trigger;
  logic          enter_ring, enter_snooze, ring_inc, snz_inc, cnt_clr;
  logic [RW-1:0] ring_tmr;
  logic [SW-1:0] snz_tmr;
  logic [TW-1:0] tone_cnt;
  logic [CW-1:0] cad_cnt;
  logic          tone_q, beep_on;

  // Seconds digits must be :00 so the match holds for exactly one second.
  assign match_now = (hr_10s  == alarm_hr_10s)  && (hr_1s  == alarm_hr_1s) &&
                     (min_10s == alarm_min_10s) && (min_1s == alarm_min_1s) &&
                     (sec_10s == 4'd0) && (sec_1s == 4'd0);
  assign trigger   = match_now & ~match_prev & ~set_alarm;

  assign ringing  = (state == RINGING);
  assign snoozing = (state == SNOOZE);

  // State register.
  // NOTE: sequential blocks use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state and control strobes; alarm_en low overrides everything.
  // NOTE: every output of this block gets a default first, otherwise latches are inferred.
  always_comb begin
    state_nx     = state;
    enter_ring   = 1'b0;
    enter_snooze = 1'b0;
    ring_inc     = 1'b0;
    snz_inc      = 1'b0;
    cnt_clr      = 1'b0;
    if (!alarm_en) begin
      state_nx = IDLE;
      cnt_clr  = 1'b1;
    end else begin
      case (state)
        IDLE:    state_nx = ARMED;
        ARMED: begin
          if (trigger) begin
            state_nx   = RINGING;
            enter_ring = 1'b1;
            cnt_clr    = 1'b1;
          end
        end
        RINGING: begin
          if (dismiss) begin
            state_nx = ARMED;
          end else if (snooze) begin
            if (snooze_cnt < SNZ_MAX) begin
              state_nx     = SNOOZE;
              enter_snooze = 1'b1;
            end else begin
              state_nx = ARMED;
            end
          end else if (tick_1Hz) begin
            if (ring_tmr == RING_LAST) state_nx = ARMED;
            else                       ring_inc = 1'b1;
          end
        end
        SNOOZE: begin
          if (dismiss) begin
            state_nx = ARMED;
          end else if (tick_1Hz) begin
            if (snz_tmr == SNZ_LAST) begin
              state_nx   = RINGING;
              enter_ring = 1'b1;
            end else begin
              snz_inc = 1'b1;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Edge detector, second timers and snooze counter.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      match_prev <= 1'b0;
      ring_tmr   <= '0;
      snz_tmr    <= '0;
      snooze_cnt <= 2'd0;
    end else begin
      match_prev <= match_now;
      if (enter_ring)    ring_tmr <= '0;
      else if (ring_inc) ring_tmr <= ring_tmr + RW'(1);
      if (enter_snooze)  snz_tmr  <= '0;
      else if (snz_inc)  snz_tmr  <= snz_tmr + SW'(1);
      if (cnt_clr)           snooze_cnt <= 2'd0;
      else if (enter_snooze) snooze_cnt <= snooze_cnt + 2'd1;
    end
  end

  // Tone divider and beep cadence; restart on every entry into RINGING.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      tone_cnt <= '0;
      tone_q   <= 1'b0;
      cad_cnt  <= '0;
      beep_on  <= 1'b0;
      buzzer   <= 1'b0;
    end else begin
      if (enter_ring) begin
        tone_cnt <= '0;
        tone_q   <= 1'b0;
        cad_cnt  <= '0;
        beep_on  <= 1'b1;
      end else if (state == RINGING) begin
        if (tone_cnt == TONE_LAST) begin
          tone_cnt <= '0;
          tone_q   <= ~tone_q;
        end else begin
          tone_cnt <= tone_cnt + TW'(1);
        end
        if (cad_cnt == CAD_LAST) begin
          cad_cnt <= '0;
          beep_on <= ~beep_on;
        end else begin
          cad_cnt <= cad_cnt + CW'(1);
        end
      end
      buzzer <= (state == RINGING) && beep_on && tone_q;
    end
  end

endmodule

// File: tb/tb_alarm_sequencer.sv
// Self-checking bench for alarm_sequencer at scaled timing.
// A reference model tracks the alarm in terms of minutes-of-day, seconds
// remaining and cycles spent ringing; outputs are compared every clock.
module tb_alarm_sequencer;

  localparam int CLK_HZ     = 1000;
  localparam int TONE_HZ    = 100;
  localparam int SNOOZE_SEC = 3;
  localparam int RING_SEC   = 4;
  localparam int MAX_SNOOZE = 2;
  localparam int TONE_DIV   = CLK_HZ / (2 * TONE_HZ);
  localparam int CAD_DIV    = CLK_HZ / 2;

  logic       clk_100MHz = 1'b0;
  logic       reset = 1'b0;
  logic       tick_1Hz = 1'b0;
  logic [3:0] hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s;
  logic [3:0] alarm_hr_10s, alarm_hr_1s, alarm_min_10s, alarm_min_1s;
  logic       alarm_en = 1'b0;
  logic       set_alarm = 1'b0;
  logic       snooze = 1'b0;
  logic       dismiss = 1'b0;
  logic       buzzer, ringing, snoozing;
  logic [1:0] snooze_cnt;

  alarm_sequencer #(
    .CLK_HZ(CLK_HZ), .TONE_HZ(TONE_HZ), .SNOOZE_SEC(SNOOZE_SEC),
    .RING_SEC(RING_SEC), .MAX_SNOOZE(MAX_SNOOZE)
  ) dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .tick_1Hz(tick_1Hz),
    .hr_10s(hr_10s), .hr_1s(hr_1s), .min_10s(min_10s), .min_1s(min_1s),
    .sec_10s(sec_10s), .sec_1s(sec_1s),
    .alarm_hr_10s(alarm_hr_10s), .alarm_hr_1s(alarm_hr_1s),
    .alarm_min_10s(alarm_min_10s), .alarm_min_1s(alarm_min_1s),
    .alarm_en(alarm_en), .set_alarm(set_alarm), .snooze(snooze), .dismiss(dismiss),
    .buzzer(buzzer), .ringing(ringing), .snoozing(snoozing), .snooze_cnt(snooze_cnt)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int checks = 0;
  int errors = 0;
  int t_sec;       // running time, seconds of day
  int alarm_min;   // alarm time, minutes of day

  // Reference model: live = alarm enabled and past the idle cycle.
  bit m_live, m_ring, m_snz, m_buz, m_prev;
  int m_cnt, m_ring_left, m_snz_left, m_k;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_time();
    int h, m, s;
    h = t_sec / 3600; m = (t_sec / 60) % 60; s = t_sec % 60;
    hr_10s  = 4'(h / 10); hr_1s  = 4'(h % 10);
    min_10s = 4'(m / 10); min_1s = 4'(m % 10);
    sec_10s = 4'(s / 10); sec_1s = 4'(s % 10);
  endtask

  task automatic drive_alarm();
    int h, m;
    h = alarm_min / 60; m = alarm_min % 60;
    alarm_hr_10s  = 4'(h / 10); alarm_hr_1s  = 4'(h % 10);
    alarm_min_10s = 4'(m / 10); alarm_min_1s = 4'(m % 10);
  endtask

  function automatic bit beep_at(int k);
    return ((k / CAD_DIV) % 2) == 0;
  endfunction

  function automatic bit tone_at(int k);
    return ((k / TONE_DIV) % 2) == 1;
  endfunction

  task automatic model_reset();
    m_live = 0; m_ring = 0; m_snz = 0; m_buz = 0; m_prev = 0;
    m_cnt = 0; m_ring_left = 0; m_snz_left = 0; m_k = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit match, trig, was_ring, enter, nb;
    match    = ((t_sec / 60) == alarm_min) && ((t_sec % 60) == 0);
    trig     = match && !m_prev && !set_alarm;
    nb       = m_ring && beep_at(m_k) && tone_at(m_k);
    was_ring = m_ring;
    enter    = 0;
    if (!alarm_en) begin
      m_live = 0; m_ring = 0; m_snz = 0; m_cnt = 0;
    end else if (!m_live) begin
      m_live = 1;
    end else if (m_ring) begin
      if (dismiss) m_ring = 0;
      else if (snooze) begin
        m_ring = 0;
        if (m_cnt < MAX_SNOOZE) begin
          m_snz = 1; m_cnt++; m_snz_left = SNOOZE_SEC;
        end
      end else if (tick_1Hz) begin
        m_ring_left--;
        if (m_ring_left == 0) m_ring = 0;
      end
    end else if (m_snz) begin
      if (dismiss) m_snz = 0;
      else if (tick_1Hz) begin
        m_snz_left--;
        if (m_snz_left == 0) begin m_snz = 0; m_ring = 1; enter = 1; end
      end
    end else if (trig) begin
      m_ring = 1; m_cnt = 0; enter = 1;
    end
    if (enter) begin m_ring_left = RING_SEC; m_k = 0; end
    else if (was_ring && m_ring) m_k++;
    m_buz  = nb;
    m_prev = match;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk_100MHz);
    #1;
    check("ringing",    8'(ringing),    8'(m_ring));
    check("snoozing",   8'(snoozing),   8'(m_snz));
    check("snooze_cnt", 8'(snooze_cnt), 8'(m_cnt));
    check("buzzer",     8'(buzzer),     8'(m_buz));
    tick_1Hz = 1'b0; snooze = 1'b0; dismiss = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic tick_sec(input int gap);
    t_sec = (t_sec + 1) % 86400;
    drive_time();
    tick_1Hz = 1'b1;
    cycle();
    idle(gap);
  endtask

  // Place the clock one second before the alarm and tick into :00.
  task automatic ring_now();
    t_sec = (alarm_min * 60 + 86399) % 86400;
    drive_time();
    idle(2);
    tick_sec(0);
  endtask

  initial begin
    model_reset();
    alarm_min = 7 * 60 + 30;
    t_sec     = 7 * 3600 + 29 * 60 + 55;
    drive_alarm();
    drive_time();

    // Reset state
    #1 reset = 1'b1;
    #1;
    check("rst_ringing", 8'(ringing), 8'd0);
    check("rst_buzzer",  8'(buzzer),  8'd0);
    check("rst_cnt",     8'(snooze_cnt), 8'd0);
    @(posedge clk_100MHz); @(posedge clk_100MHz); #1;
    reset = 1'b0;
    alarm_en = 1'b1;
    cycle();

    // Ring on match, run to timeout across a cadence change
    for (int i = 0; i < 4; i++) tick_sec(2);
    tick_sec(0);
    check("ring_on_match", 8'(ringing), 8'd1);
    for (int i = 0; i < 3; i++) tick_sec(300);
    tick_sec(0);
    check("timeout_armed", 8'(ringing), 8'd0);
    cycle();
    check("timeout_buzzer", 8'(buzzer), 8'd0);
    for (int i = 0; i < 5; i++) tick_sec(1);
    check("no_retrigger", 8'(ringing), 8'd0);

    // Snooze chain up to the limit
    ring_now();
    idle(12);
    snooze = 1'b1; cycle();
    check("snz1_flag", 8'(snoozing),   8'd1);
    check("snz1_cnt",  8'(snooze_cnt), 8'd1);
    for (int i = 0; i < 3; i++) tick_sec(2);
    check("snz1_rering", 8'(ringing), 8'd1);
    snooze = 1'b1; cycle();
    check("snz2_cnt", 8'(snooze_cnt), 8'd2);
    for (int i = 0; i < 3; i++) tick_sec(2);
    snooze = 1'b1; cycle();
    check("snz3_armed", 8'(ringing | snoozing), 8'd0);
    check("snz3_cnt",   8'(snooze_cnt), 8'd2);

    // Dismiss within second :00 must not retrigger
    ring_now();
    check("ring2_cnt_clr", 8'(snooze_cnt), 8'd0);
    dismiss = 1'b1; cycle();
    idle(20);
    check("dismiss_no_retrig", 8'(ringing), 8'd0);

    // Snooze and dismiss together
    ring_now();
    snooze = 1'b1; cycle();
    for (int i = 0; i < 3; i++) tick_sec(1);
    snooze = 1'b1; dismiss = 1'b1; cycle();
    check("snz_dis_armed", 8'(snoozing),   8'd0);
    check("snz_dis_cnt",   8'(snooze_cnt), 8'd1);

    // set_alarm across :00 suppresses the event, no late trigger
    t_sec = alarm_min * 60 - 1; drive_time(); idle(2);
    set_alarm = 1'b1;
    tick_sec(3);
    set_alarm = 1'b0;
    idle(10);
    check("set_alarm_supp", 8'(ringing), 8'd0);

    // alarm_en low mid-snooze
    ring_now();
    snooze = 1'b1; cycle();
    alarm_en = 1'b0; cycle();
    check("en_off_snz", 8'(snoozing),   8'd0);
    check("en_off_cnt", 8'(snooze_cnt), 8'd0);
    alarm_en = 1'b1; idle(2);

    // Randomized alarm times and user actions
    for (int r = 0; r < 6; r++) begin
      alarm_min = int'($urandom_range(0, 1439));
      drive_alarm();
      ring_now();
      for (int c = 0; c < 150; c++) begin
        int u;
        u = int'($urandom_range(0, 99));
        if (u < 4) begin
          t_sec = (t_sec + 1) % 86400; drive_time(); tick_1Hz = 1'b1;
        end else if (u < 6) snooze = 1'b1;
        else if (u == 6) dismiss = 1'b1;
        else if (u == 7) begin snooze = 1'b1; dismiss = 1'b1; end
        else if (u == 8) alarm_en = 1'b0;
        cycle();
        alarm_en = 1'b1;
      end
      idle(2);
    end

    // Asynchronous reset while the buzzer is high
    alarm_min = 7 * 60 + 30; drive_alarm();
    ring_now();
    for (int i = 0; i < 60 && !m_buz; i++) cycle();
    check("buzzer_high_wait", 8'(m_buz), 8'd1);
    check("buzzer_high", 8'(buzzer), 8'd1);
    #2 reset = 1'b1;
    #1;
    check("async_buzzer",  8'(buzzer),   8'd0);
    check("async_ringing", 8'(ringing),  8'd0);
    check("async_snz",     8'(snoozing), 8'd0);
    model_reset();
    @(posedge clk_100MHz); @(posedge clk_100MHz); #1;
    reset = 1'b0;
    check("post_rst_ring", 8'(ringing),    8'd0);
    check("post_rst_cnt",  8'(snooze_cnt), 8'd0);
    idle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
